// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared pixel index, color and scan-state types for the GPU frame path
package gpu_pkg;

  localparam int PIXEL_IDX_W = 19;
  localparam int COLOR_W     = 8;

  // Pixel address/index type, shared with the blending writer
  typedef logic [PIXEL_IDX_W-1:0] pixel_idx_t;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  // One output-buffer entry: the color plus the index it was read from
  typedef struct packed {
    rgb_t       rgb;
    pixel_idx_t idx;
  } pix_entry_t;

  localparam int ENTRY_W = $bits(pix_entry_t);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } scan_state_t;

endpackage

// File: rtl/scanout_fifo.sv
// rtl/scanout_fifo.sv - synchronous output buffer of {rgb_t, index} entries
module scanout_fifo
  import gpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic [ENTRY_W-1:0] head,
  output logic [CNT_W-1:0]   count,
  output logic               empty,
  output logic               full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  // Storage is cleared too so the head reads back as zero after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/frame_scanout.sv
// rtl/frame_scanout.sv - sequential frame-buffer reader streaming pixels to the display; SCANOUT_UNDERRUN_CNT_EN adds an underrun counter
module frame_scanout
  import gpu_pkg::*;
#(
  parameter int NUM_PIXELS  = 307200,
  parameter int MEM_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_ready,
  output logic        mem_read,
  output logic [18:0] mem_addr,
  input  logic [7:0]  mem_r,
  input  logic [7:0]  mem_g,
  input  logic [7:0]  mem_b,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_r,
  output logic [7:0]  pix_g,
  output logic [7:0]  pix_b,
  output logic [18:0] pix_number,
  output logic        pix_last,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] underrun_count
);

  localparam int         CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam pixel_idx_t LAST_IDX = pixel_idx_t'(NUM_PIXELS - 1);

  scan_state_t      state;
  scan_state_t      state_nxt;
  pixel_idx_t       addr;
  logic [MEM_LATENCY-1:0] rd_vld;
  pixel_idx_t       rd_idx [MEM_LATENCY];
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic [7:0]       credit_used;
  logic             issue;
  logic             push;
  logic             xfer;
  pix_entry_t       push_entry;
  pix_entry_t       head;

  // Credits in use: reads still in the memory pipe plus entries already buffered
  always_comb begin
    credit_used = 8'(fifo_count);
    for (int i = 0; i < MEM_LATENCY; i++) credit_used = credit_used + 8'(rd_vld[i]);
  end

  assign issue    = (state == SCAN) && (credit_used < 8'(FIFO_DEPTH));
  assign mem_read = issue;
  assign mem_addr = addr;
  assign xfer     = pix_valid && pix_ready;
  assign busy     = (state != IDLE);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_ready) state_nxt = SCAN;
      SCAN:    if (issue && addr == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   if (xfer && pix_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, read address counter and end-of-frame pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr       <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= (state == DRAIN) && xfer && pix_last;
      if (state == IDLE && frame_ready) addr <= '0;
      else if (issue) addr <= (addr == LAST_IDX) ? '0 : addr + 1'b1;
    end
  end

  // Read-valid/index pipe matching the memory latency; reset drops in-flight returns
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_vld <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) rd_idx[i] <= '0;
    end else begin
      rd_vld[0] <= issue;
      rd_idx[0] <= addr;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        rd_vld[i] <= rd_vld[i-1];
        rd_idx[i] <= rd_idx[i-1];
      end
    end
  end

  assign push       = rd_vld[MEM_LATENCY-1];
  assign push_entry = '{rgb: '{r: mem_r, g: mem_g, b: mem_b}, idx: rd_idx[MEM_LATENCY-1]};

  scanout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (xfer),
    .head      (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign pix_valid  = !fifo_empty;
  assign pix_r      = head.rgb.r;
  assign pix_g      = head.rgb.g;
  assign pix_b      = head.rgb.b;
  assign pix_number = head.idx;
  assign pix_last   = pix_valid && (head.idx == LAST_IDX);

  // The credit rule must keep returning data from ever meeting a full buffer
  assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

`ifdef SCANOUT_UNDERRUN_CNT_EN
  logic [15:0] underrun_q;

  // Saturating count of cycles where the display wanted a pixel and none was ready
  always_ff @(posedge clk) begin
    if (reset) underrun_q <= '0;
    else if (state == IDLE && frame_ready) underrun_q <= '0;
    else if (state != IDLE && pix_ready && !pix_valid && underrun_q != 16'hFFFF)
      underrun_q <= underrun_q + 16'd1;
  end

  assign underrun_count = underrun_q;
`else
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_frame_scanout.sv
// tb/tb_frame_scanout.sv - directed self-checking bench for frame_scanout
module tb_frame_scanout;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_ready;
  logic        mem_read;
  logic [18:0] mem_addr;
  logic [7:0]  mem_r, mem_g, mem_b;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic [18:0] pix_number;
  logic        pix_last;
  logic        busy;
  logic        frame_done;
  logic [15:0] underrun_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  frame_scanout #(
    .NUM_PIXELS  (16),
    .MEM_LATENCY (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_ready    (frame_ready),
    .mem_read       (mem_read),
    .mem_addr       (mem_addr),
    .mem_r          (mem_r),
    .mem_g          (mem_g),
    .mem_b          (mem_b),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_r          (pix_r),
    .pix_g          (pix_g),
    .pix_b          (pix_b),
    .pix_number     (pix_number),
    .pix_last       (pix_last),
    .busy           (busy),
    .frame_done     (frame_done),
    .underrun_count (underrun_count)
  );

  // Two-cycle memory: data reflects the address presented two cycles earlier
  logic [18:0] p0, p1;
  always @(posedge clk) begin
    p0 <= mem_addr;
    p1 <= p0;
  end
  assign mem_r = p1[7:0];
  assign mem_g = p1[15:8];
  assign mem_b = {5'b0, p1[18:16]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 1) return !(cyc >= 6 && cyc < 16);
    if (mode == 2) return (cyc % 2) == 0;
    return 1'b1;
  endfunction

  // mode 0: ready high, 1: 10-cycle stall, 2: alternating ready,
  // 3: stray frame_ready pulses in SCAN/DRAIN, 4: frame_ready held high
  task automatic run_frame(input int mode, input bit start, input string name);
    int cyc = 0, nxt = 0, rd_cnt = 0, first_valid = -1, last_xfer = -100;
    int done_cyc = -1, stall_reads = 0;
    logic busy_at_done = 1'b1;
    logic held = 1'b0;
    logic [42:0] held_val = '0;
    logic [18:0] idx;
    if (start) begin
      frame_ready = 1'b1;
      tick();
    end
    while (cyc < 200 && done_cyc < 0) begin
      pix_ready   = ready_for(mode, cyc);
      frame_ready = (mode == 4) || (mode == 3 && (cyc == 5 || cyc == 17));
      if (first_valid < 0 && pix_valid) first_valid = cyc;
      if (held) begin
        check($sformatf("%s_valid_held_c%0d", name, cyc), {31'b0, pix_valid}, 32'd1);
        check($sformatf("%s_data_held_c%0d", name, cyc),
              {pix_number, pix_r, pix_g, pix_b} ^ held_val, 32'd0);
      end
      held     = pix_valid && !pix_ready;
      held_val = {pix_number, pix_r, pix_g, pix_b};
      if (mem_read) begin
        check($sformatf("%s_addr_%0d", name, rd_cnt), {13'b0, mem_addr}, rd_cnt);
        rd_cnt++;
        if (mode == 1 && cyc >= 6 && cyc < 16) stall_reads++;
      end
      if (frame_done) begin
        done_cyc     = cyc;
        busy_at_done = busy;
      end
      if (pix_valid && pix_ready) begin
        idx = nxt[18:0];
        check($sformatf("%s_idx_%0d", name, nxt), {13'b0, pix_number}, nxt);
        check($sformatf("%s_rgb_%0d", name, nxt), {8'b0, pix_r, pix_g, pix_b},
              {8'b0, idx[7:0], idx[15:8], 5'b0, idx[18:16]});
        check($sformatf("%s_last_%0d", name, nxt), {31'b0, pix_last}, (nxt == 15) ? 1 : 0);
        last_xfer = cyc;
        nxt++;
      end
      tick();
      cyc++;
    end
    check({name, "_timeout"}, {31'b0, done_cyc >= 0}, 32'd1);
    check({name, "_first_valid"}, first_valid, 32'd3);
    check({name, "_count"}, nxt, 32'd16);
    check({name, "_reads"}, rd_cnt, 32'd16);
    check({name, "_done_lat"}, done_cyc, last_xfer + 1);
    check({name, "_busy_done"}, {31'b0, busy_at_done}, 32'd0);
    if (mode == 1) check({name, "_stall_reads"}, stall_reads, 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    frame_ready = 1'b0;
    pix_ready   = 1'b0;
    repeat (3) tick();
    check("rst_valid", {31'b0, pix_valid}, 32'd0);
    check("rst_read", {31'b0, mem_read}, 32'd0);
    check("rst_addr", {13'b0, mem_addr}, 32'd0);
    check("rst_busy_done", {30'b0, busy, frame_done}, 32'd0);
    check("rst_pix", {pix_number, pix_r, pix_g, pix_b} == '0, 32'd1);
    check("rst_underrun", {16'b0, underrun_count}, 32'd0);
    reset = 1'b0;
    tick();

    run_frame(0, 1'b1, "basic");
`ifdef SCANOUT_UNDERRUN_CNT_EN
    check("underrun", {16'b0, underrun_count}, 32'd3);
`else
    check("underrun", {16'b0, underrun_count}, 32'd0);
`endif
    run_frame(1, 1'b1, "bp");
    run_frame(2, 1'b1, "alt");

    // Reset while scanning, with pixel 7 presented
    frame_ready = 1'b1;
    pix_ready   = 1'b1;
    tick();
    frame_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (pix_valid && pix_number == 19'd7) break;
      tick();
    end
    check("midrst_reached7", {13'b0, pix_number}, 32'd7);
    check("midrst_busy_before", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_outs", {mem_read, pix_valid, pix_last, busy, frame_done, mem_addr,
                          pix_number, pix_r, pix_g, pix_b} == '0, 32'd1);
    begin
      int late_valid = 0;
      for (int i = 0; i < 6; i++) begin
        if (pix_valid || busy || mem_read) late_valid++;
        tick();
      end
      check("midrst_quiet", late_valid, 32'd0);
    end
    run_frame(0, 1'b1, "restart");

    run_frame(3, 1'b1, "stray");
    frame_ready = 1'b0;
    tick();
    check("stray_idle", {30'b0, busy, mem_read}, 32'd0);

    run_frame(4, 1'b1, "held1");
    check("held_restart_busy", {31'b0, busy}, 32'd1);
    run_frame(4, 1'b0, "held2");
    frame_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_scanout.md
Name: frame_scanout

Overview:
- Reader-side counterpart of the blending writer.
- Once the blender signals a completed frame, it reads the frame buffer sequentially from pixel 0 to NUM_PIXELS-1.
- It streams the pixels to the display path over a valid/ready interface.
- Reads go to a fixed-latency memory port; a small credit-controlled FIFO absorbs downstream backpressure.

Parameters:
- NUM_PIXELS, 307200, pixels per frame (640x480); must fit in 19 bits.
- MEM_LATENCY, 2, cycles from mem_read asserted to mem_r/g/b valid; range 1..4.
- FIFO_DEPTH, 4, output buffer entries; power of two, at least MEM_LATENCY+1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- frame_ready  in  1  frame in the buffer is complete; sampled only in IDLE.
- mem_read  out  1  read strobe, one pixel per cycle.
- mem_addr  out  19  pixel address of the read.
- mem_r, mem_g, mem_b  in  8 each  read data, valid exactly MEM_LATENCY cycles after mem_read.
- pix_valid  out  1  output pixel available.
- pix_ready  in  1  downstream accepts; transfer occurs when pix_valid && pix_ready.
- pix_r, pix_g, pix_b  out  8 each  pixel color.
- pix_number  out  19  index of the presented pixel.
- pix_last  out  1  presented pixel is NUM_PIXELS-1.
- busy  out  1  high in SCAN or DRAIN.
- frame_done  out  1  one-cycle pulse after the last pixel transfers.
- underrun_count  out  16  see Optional Feature.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Address counter 0, FIFO empty, in-flight pipeline cleared.
  - Reset mid-frame drops all in-flight returns; scanning restarts only on the next frame_ready.
- States:
  - IDLE: frame_ready=1 -> SCAN; address counter = 0.
  - SCAN: issue reads. After the read of address NUM_PIXELS-1 is issued -> DRAIN.
  - DRAIN: no reads. When the last pixel transfers (pix_last && pix_valid && pix_ready) -> IDLE, with frame_done=1 in that same-edge registered cycle.
  - frame_ready is ignored in SCAN and DRAIN. frame_ready held high in IDLE starts a new frame on the cycle after frame_done.
- Read issue:
  - mem_read=1 in SCAN only when in_flight + fifo_count < FIFO_DEPTH (credit rule); mem_addr = address counter; counter increments on issue.
  - in_flight is a MEM_LATENCY-deep valid shift register, so the FIFO can never overflow.
  - A returning word is pushed into the FIFO on the cycle its valid bit exits the shift register; its pixel index travels with it.
- FIFO:
  - Registered outputs; pix_valid = !empty.
  - Simultaneous push and pop leave the count unchanged.
  - Pop occurs only on transfer; push into a full FIFO is impossible by construction and is assertion-checked.
- Outputs are stable while pix_valid && !pix_ready.
- Latency: first pix_valid appears MEM_LATENCY+1 cycles after frame_ready is sampled in IDLE.
- Throughput: one pixel per cycle with pix_ready held high.
- busy = (state != IDLE).

Optional Feature:
- Macro: SCANOUT_UNDERRUN_CNT_EN.
- Defined:
  - underrun_count increments, saturating at 16'hFFFF, on each SCAN/DRAIN cycle with pix_ready=1 && pix_valid=0.
  - Cleared by reset and on IDLE->SCAN.
- Undefined: underrun_count is tied to 0 and no counter logic exists.

Decomposition:
- Shared package gpu_pkg holds:
  - PIXEL_IDX_W=19, COLOR_W=8;
  - rgb_t packed struct {r,g,b};
  - scan_state_t enum {IDLE, SCAN, DRAIN}.
- The address/index type is shared with the blender.
- Sub-module scanout_fifo: synchronous FIFO of {rgb_t, index} with push, pop, count, empty, full.

Test Plan:
- Test memory model returns r=addr[7:0], g=addr[15:8], b={5'b0,addr[18:16]}. Run with NUM_PIXELS=16, MEM_LATENCY=2, FIFO_DEPTH=4.
- Basic frame: pulse frame_ready with pix_ready=1.
  - First pix_valid 3 cycles later.
  - 16 consecutive transfers; pixel 5 = (5,0,0); pix_last only on index 15.
  - frame_done pulse one cycle after the index-15 transfer; busy back to 0.
- Backpressure: pix_ready=0 for 10 cycles mid-frame.
  - mem_read stops once in_flight+fifo_count reaches 4.
  - Outputs held stable; no pixel lost or duplicated; the index sequence 0..15 is intact.
- Alternating pix_ready (1,0,1,0...): all 16 pixels delivered in order; the FIFO never overflows (assertion silent).
- Reset asserted in SCAN at pixel 7:
  - Next cycle all outputs are 0, state IDLE, late memory returns ignored.
  - A new frame_ready restarts from index 0.
- frame_ready pulses in SCAN and DRAIN: no effect. frame_ready held high: a second frame starts right after frame_done and again delivers indices 0..15.
- With SCANOUT_UNDERRUN_CNT_EN and pix_ready=1 throughout: underrun_count = 3, the wait before the first pixel.
